// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and width defaults for the SRAM arbiter.
//   state_t : bus-cycle FSM states
//   owner_t : which requester the current bus cycle serves
package ram_arbiter_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: pipeline-side request/response bundle plus SRAM control pins.
//   master : pipeline side (drives requests, receives data/ready/stall/SRAM pins)
//   slave  : arbiter side
interface ram_arbiter_if import ram_arbiter_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall;
    logic              ram1_en;
    logic              ram1_oe;
    logic              ram1_we;
    logic [ADDR_W-1:0] ram1_addr;

    modport master (
        output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
        input  if_data, if_ready, mem_rdata, mem_ready, stall,
               ram1_en, ram1_oe, ram1_we, ram1_addr
    );
    modport slave (
        input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
        output if_data, if_ready, mem_rdata, mem_ready, stall,
               ram1_en, ram1_oe, ram1_we, ram1_addr
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SRAM between IF fetch and MEM load/store, MEM first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response/stall and SRAM control pins (slave modport)
//   ram1_data  : SRAM data bus, driven only during write cycles
module ram_arbiter import ram_arbiter_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_CYCLES = 1,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    inout  wire  [DATA_W-1:0] ram1_data
);
    localparam int MAX_CYC = RD_CYCLES > WR_CYCLES ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              en_q, en_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              drive_q, drive_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            en_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            en_q        <= en_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            drive_q     <= drive_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            IDLE: begin
                // A simultaneous read+write request is served as a write.
                if (bus.mem_write) begin
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    owner_d = OWN_MEM;
                    state_d = WR_SETUP;
                end else if (bus.mem_read) begin
                    addr_d  = bus.mem_addr;
                    owner_d = OWN_MEM;
                    cnt_d   = CNT_W'(RD_CYCLES - 1);
                    state_d = RD;
                end else if (bus.if_req) begin
                    addr_d  = bus.if_addr;
                    owner_d = OWN_IF;
                    cnt_d   = CNT_W'(RD_CYCLES - 1);
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if_data_d   = owner_q == OWN_IF  ? ram1_data : if_data_q;
                    mem_rdata_d = owner_q == OWN_MEM ? ram1_data : mem_rdata_q;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                cnt_d   = CNT_W'(WR_CYCLES - 1);
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == '0) state_d = WR_HOLD;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Pin values are derived from the next state so they leave a flop.
        en_d        = state_d == IDLE || state_d == DONE;
        oe_d        = state_d != RD;
        we_d        = state_d != WR_PULSE;
        drive_d     = state_d == WR_SETUP || state_d == WR_PULSE || state_d == WR_HOLD;
        if_ready_d  = state_d == DONE && owner_d == OWN_IF;
        mem_ready_d = state_d == DONE && owner_d == OWN_MEM;
    end

    assign ram1_data     = drive_q ? wdata_q : 'z;
    assign bus.ram1_en   = en_q;
    assign bus.ram1_oe   = oe_q;
    assign bus.ram1_we   = we_q;
    assign bus.ram1_addr = addr_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.stall     = ((bus.mem_read | bus.mem_write) & ~mem_ready_q) | (bus.if_req & ~if_ready_q);
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Time-multiplexes the single external SRAM (RAM1) between the IF stage (instruction fetch) and the MEM stage (load/store) of the five-stage pipeline. It runs the SRAM read and write bus cycles with correct OE/WE/EN sequencing and drives the pipeline-wide stall while either requester waits. MEM always has priority over IF. It sits between the pipeline registers and the board SRAM pins, in place of a direct memory controller.

## Interface
Parameters:
- ADDR_W, 16, SRAM and requester address width
- DATA_W, 16, SRAM data width
- RD_CYCLES, 1, cycles OE is held low per read (≥1)
- WR_CYCLES, 2, cycles WE is held low per write (≥1)

Ports:
- CLK  in  1  single system clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- ifReq  in  1  IF wants the instruction at ifAddr
- ifAddr  in  ADDR_W  fetch address (PC)
- ifData  out  DATA_W  fetched instruction, valid while ifReady=1
- ifReady  out  1  one-cycle completion pulse for IF
- memRead  in  1  MEM load request
- memWrite  in  1  MEM store request
- memAddr  in  ADDR_W  load/store address (ALU result)
- memWData  in  DATA_W  store data
- memRData  out  DATA_W  load data, valid while memReady=1
- memReady  out  1  one-cycle completion pulse for MEM
- stall  out  1  freeze PC, IF_ID, ID_EX, EX_MEM, MEM_WB
- ram1EN, ram1OE, ram1WE  out  1 each  SRAM controls, active-low
- ram1Addr  out  ADDR_W  SRAM address
- ram1Data  inout  DATA_W  SRAM data, high-Z unless writing

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: if memWrite, latch memAddr and memWData, owner=MEM, go to WR_SETUP. Else if memRead, latch memAddr, owner=MEM, go to RD. Else if ifReq, latch ifAddr, owner=IF, go to RD. Otherwise stay in IDLE.
- memRead and memWrite high together: the request is treated as a write.
- RD: EN=0, OE=0, WE=1, bus Z, for RD_CYCLES cycles (down-counter). At the last RD edge, capture ram1Data into the owner's data register, then go to DONE.
- WR_SETUP: 1 cycle, EN=0, OE=1, WE=1, address and data driven.
- WR_PULSE: WR_CYCLES cycles with WE=0, address and data held.
- WR_HOLD: 1 cycle with WE=1, data still driven, then go to DONE.
- DONE: EN=1, OE=1, WE=1, bus Z. The owner's ready is 1 for exactly this cycle; then go to IDLE. No new request is accepted in DONE, so a request held during the ready cycle does not retrigger.
- ifData and memRData hold their last captured value until the next capture.
- stall = ((memRead|memWrite) & ~memReady) | (ifReq & ~ifReady). This is combinational from the inputs and registered ready flags.
- Request dropped mid-operation: the bus cycle still completes and ready still pulses; the requester ignores it.
- IF starvation while MEM requests continue back-to-back is acceptable, because the pipeline is stalled.

## Timing
- Reset (asynchronous, immediate): state=IDLE, ram1EN=1, ram1OE=1, ram1WE=1, ram1Addr=0, ram1Data Z, ifReady=0, memReady=0, ifData=0, memRData=0, counter=0.
- Reset mid-write deasserts WE in the same instant, with no glitch low.
- All SRAM control, address and drive-enable outputs are registered; none are combinational from requests.
- Read, request seen in IDLE at cycle 0: RD in cycles 1..RD_CYCLES, ready in cycle RD_CYCLES+1. Default: ready in cycle 2.
- Write: WR_SETUP in cycle 1, WR_PULSE in cycles 2..WR_CYCLES+1, WR_HOLD in cycle WR_CYCLES+2, ready in cycle WR_CYCLES+3. Default: ready in cycle 5.
- Throughput: back-to-back reads occupy RD_CYCLES+2 cycles each, including the IDLE cycle.
- Address and data stay stable from WR_SETUP through WR_HOLD inclusive.

## Structure
- Shared package ram_arbiter_pkg holds the state enum, the owner enum (OWN_IF, OWN_MEM), and defaults for ADDR_W and DATA_W.
- No sub-module. The FSM, cycle counter and tristate buffer all live in ram_arbiter.

## Test plan
- Reset then idle, with no requests: EN, OE and WE all 1, ram1Data Z, stall=0, both ready signals 0.
- IF read: ifReq=1, ifAddr=0x0010, SRAM returns 0x4A21 → OE low in cycle 1, ifReady=1 and ifData=0x4A21 in cycle 2, stall low in cycle 2.
- MEM write: memWrite=1, memAddr=0x8000, memWData=0xBEEF → WE low in cycles 2–3, bus driven with 0xBEEF in cycles 1–4, memReady in cycle 5. A model SRAM then holds 0xBEEF at 0x8000.
- Collision: ifReq and memRead both raised in cycle 0 → MEM is served first (memReady in cycle 2), IF starts in cycle 4 (ifReady in cycle 5). stall stays high until cycle 5.
- memRead and memWrite raised together → a write cycle is performed and OE never goes low.
- RST asserted during WR_PULSE → WE=1 and bus Z immediately. After release, state is IDLE and no ready pulse occurs.
